// File: rtl/trivium_ks_consumer.sv
// Keystream consumer for a Trivium-style engine: discards warm-up output, then
// packs 8 keystream bits per byte and XORs them onto a ready/valid byte stream.
module trivium_ks_consumer #(
  parameter int unsigned WARMUP_CYC = 1152,
  parameter int unsigned CNT_W      = 11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       ks_bit_i,
  output logic       ks_ce_o,
  input  logic [7:0] dat_i,
  input  logic       dat_val_i,
  output logic       dat_rdy_o,
  output logic [7:0] dat_o,
  output logic       dat_val_o,
  input  logic       dat_rdy_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  // With no warm-up the WARMUP state is never entered, so its terminal count is unused.
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP_CYC > 32'd0) ? WARMUP_CYC - 32'd1 : 32'd0);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(32'd7);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_clr_s;
  logic             load_s;
  logic [7:0]       ks_byte_r;
  logic [7:0]       dat_r;
  logic             dat_val_r;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the counter is cleared on every state entry.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = (WARMUP_CYC == 32'd0) ? ST_FILL : ST_WARMUP;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (cnt_r == WARM_LAST) begin
          state_nxt_s = ST_FILL;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_FILL: begin
        if (cnt_r == FILL_LAST) begin
          state_nxt_s = ST_READY;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_READY: begin
        if (load_s) begin
          state_nxt_s = ST_FILL;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_clr_s   = 1'b1;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ks_ce_o   = 1'b0;
    busy_o    = 1'b0;
    dat_rdy_o = 1'b0;
    case (state_r)
      ST_WARMUP, ST_FILL: begin
        ks_ce_o = 1'b1;
        busy_o  = 1'b1;
      end
      ST_READY: begin
        dat_rdy_o = !dat_val_r | dat_rdy_i;
      end
      default: begin
        ks_ce_o   = 1'b0;
        busy_o    = 1'b0;
        dat_rdy_o = 1'b0;
      end
    endcase
    load_s = dat_val_i & dat_rdy_o;
  end

  // Cycle counter, advancing only while the engine is being clocked.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (cnt_clr_s) begin
      cnt_r <= '0;
    end else if (ks_ce_o) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Keystream byte: shifting in at the MSB puts the first sampled bit in bit 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ks_byte_r <= 8'h00;
    end else if (state_r == ST_FILL) begin
      ks_byte_r <= {ks_bit_i, ks_byte_r[7:1]};
    end else begin
      ks_byte_r <= ks_byte_r;
    end
  end

  // Output byte register; a load wins over a simultaneous drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_r     <= 8'h00;
      dat_val_r <= 1'b0;
    end else if (load_s) begin
      dat_r     <= dat_i ^ ks_byte_r;
      dat_val_r <= 1'b1;
    end else if (dat_val_r && dat_rdy_i) begin
      dat_r     <= dat_r;
      dat_val_r <= 1'b0;
    end else begin
      dat_r     <= dat_r;
      dat_val_r <= dat_val_r;
    end
  end

  assign dat_o     = dat_r;
  assign dat_val_o = dat_val_r;

endmodule

// File: doc/trivium_ks_consumer.md
TRIVIUM_KS_CONSUMER -- requirements
Module: trivium_ks_consumer

Interface
REQ-001 SHALL have parameter WARMUP_CYC, default 1152, which sets the number of discarded keystream cycles after start.
REQ-002 SHALL have parameter CNT_W, default 11, which sets the width of the internal cycle counter; it SHALL satisfy 2^CNT_W > WARMUP_CYC.
REQ-003 SHALL have port clk_i, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: the reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit: a one-cycle pulse meaning the cipher engine registers are loaded and keystream may begin.
REQ-006 SHALL have port ks_bit_i, input, 1 bit: the keystream bit from the cipher engine, combinational from engine state.
REQ-007 SHALL have port ks_ce_o, output, 1 bit: the shift enable to the cipher engine (drives engine ce_i).
REQ-008 SHALL have port dat_i, input, 8 bits: the plaintext or ciphertext byte in.
REQ-009 SHALL have port dat_val_i, input, 1 bit: dat_i is valid.
REQ-010 SHALL have port dat_rdy_o, output, 1 bit: the block accepts dat_i this cycle.
REQ-011 SHALL have port dat_o, output, 8 bits: the XOR result byte out.
REQ-012 SHALL have port dat_val_o, output, 1 bit: dat_o is valid.
REQ-013 SHALL have port dat_rdy_i, input, 1 bit: the downstream accepts dat_o.
REQ-014 SHALL have port busy_o, output, 1 bit: high in WARMUP and FILL.

Function
REQ-015 SHALL implement states IDLE, WARMUP, FILL, READY.
REQ-016 IDLE: start_i=1 -> WARMUP, counter cleared; start_i is ignored in all other states.
REQ-017 SHALL drive ks_ce_o = 1 exactly while in WARMUP or FILL (combinational from state), and 0 otherwise.
REQ-018 WARMUP: ks_ce_o held for exactly WARMUP_CYC consecutive cycles, ks_bit_i discarded, then -> FILL.
REQ-019 FILL: 8 cycles; each cycle sample ks_bit_i and shift it into the 8-bit keystream byte; the first bit sampled SHALL land in bit 0, the last in bit 7; after the 8th cycle -> READY.
REQ-020 WARMUP=0 edge case: WARMUP_CYC=0 SHALL go IDLE -> FILL directly.
REQ-021 SHALL hold the keystream byte constant and ks_ce_o at 0 in READY.
REQ-022 READY: dat_rdy_o = !dat_val_o | dat_rdy_i; dat_rdy_o = 0 in all other states.
REQ-023 Input handshake: on dat_val_i & dat_rdy_o, dat_o <= dat_i ^ keystream byte, dat_val_o <= 1, state -> FILL (next byte generated).
REQ-024 Output handshake: dat_val_o & dat_rdy_i with no simultaneous load -> dat_val_o <= 0; on a simultaneous drain and load, the new byte replaces the old one and dat_val_o stays 1.
REQ-025 SHALL hold dat_o and dat_val_o stable while dat_val_o=1 and dat_rdy_i=0.
REQ-026 Output drain SHALL proceed in any state, including FILL; IDLE is reachable only via reset.
REQ-027 Latency: start_i sampled at cycle 0 -> ks_ce_o=1 cycles 1..WARMUP_CYC+8 -> dat_rdy_o may assert at cycle WARMUP_CYC+9; input accepted at cycle t -> dat_val_o=1 at t+1.
REQ-028 Throughput: at most 1 byte per 9 cycles (8 FILL + 1 READY).
REQ-029 Counter SHALL saturate-free wrap only via explicit clear on each state entry; no other arithmetic.

Reset
REQ-030 On rst_i=1 at a clock edge: state IDLE, counter 0, keystream byte 0x00, dat_o 0x00, dat_val_o 0, dat_rdy_o 0, ks_ce_o 0, busy_o 0.
REQ-031 Reset mid-WARMUP or mid-FILL SHALL abort immediately; ks_ce_o=0 in the cycle following reset; a pending dat_val_o is dropped.
REQ-032 After reset release, the block SHALL stay IDLE until start_i.

Verification
REQ-033 WARMUP_CYC=4, start_i at cycle 0 -> ks_ce_o high cycles 1..12 only; dat_rdy_o=1 at cycle 13.
REQ-034 ks_bit_i pattern 1,0,1,1,0,0,0,1 in FILL -> keystream 0x8D; dat_i=0xFF accepted -> dat_o=0x72, dat_val_o=1 the next cycle.
REQ-035 dat_rdy_i=0 for 20 cycles after a result -> dat_o unchanged, dat_rdy_o=0 once READY is re-entered; then dat_rdy_i=1 -> drain and accept in the same cycle.
REQ-036 start_i pulsed during WARMUP -> no restart; ks_ce_o count unchanged.
REQ-037 rst_i at the 3rd FILL cycle -> ks_ce_o=0 next cycle, all outputs at reset values, IDLE until a new start_i.
REQ-038 WARMUP_CYC=0 -> start_i at cycle 0 -> ks_ce_o high cycles 1..8; dat_rdy_o=1 at cycle 9.
